// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared FSM state type and default register-file geometry for reg_dump.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam int REG_NUM_REGS = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_DATA_W   = 32;

endpackage

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - walks the register-file read port x0..x(N-1) and streams {addr, value} beats.
// Define REG_DUMP_NONZERO_ONLY_EN to skip zero-valued registers (the last register is always sent).
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = REG_NUM_REGS,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic              is_last;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic              last_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;

  // The terminal compare always precedes the increment, so idx_q never wraps.
  assign idx_d   = idx_q + ADDR_W'(1);
  assign is_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= READ;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
`ifdef REG_DUMP_NONZERO_ONLY_EN
          if ((rf_data_i == '0) && !is_last) begin
            idx_q <= idx_d;
          end else
`endif
          begin
            out_data_q <= rf_data_i;
            out_addr_q <= idx_q;
            last_q     <= is_last;
            valid_q    <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          // Beat registers double as the holding stage while the sink stalls.
          if (out_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (is_last) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_d;
              state_q <= READ;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rf_addr_o   = idx_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_reg_dump.sv
// tb/tb_reg_dump.sv - scoreboard bench for reg_dump; honours REG_DUMP_NONZERO_ONLY_EN.
module tb_reg_dump;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REG_DUMP_NONZERO_ONLY_EN
  localparam int EXP_FIRST = 3;
  localparam int EXP_TOTAL = 36;
`else
  localparam int EXP_FIRST = 2;
  localparam int EXP_TOTAL = 65;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] rf_addr_o;
  logic [DW-1:0] rf_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [AW-1:0] out_addr_o;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;

  logic [DW-1:0] rf_mem [NR];
  beat_t         exp_q [$];
  int            checks   = 0;
  int            errors   = 0;
  int            done_cnt = 0;

  reg_dump #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rf_addr_o   (rf_addr_o),
    .rf_data_i   (rf_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_addr_o  (out_addr_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o)
  );

  always #5 clk_i = ~clk_i;

  assign rf_data_i = rf_mem[rf_addr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-written expected stream for the preload x1=0x12345678, x2=0x87654321.
  task automatic push_dump();
`ifdef REG_DUMP_NONZERO_ONLY_EN
    exp_q.push_back('{addr: 5'd1,  data: 32'h1234_5678, last: 1'b0});
    exp_q.push_back('{addr: 5'd2,  data: 32'h8765_4321, last: 1'b0});
    exp_q.push_back('{addr: 5'd31, data: 32'h0000_0000, last: 1'b1});
`else
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back('{addr: AW'(i),
                        data: (i == 1) ? 32'h1234_5678 : (i == 2) ? 32'h8765_4321 : 32'h0,
                        last: (i == NR - 1)});
    end
`endif
  endtask

  // Monitor: compares any presented beat against the queue head, pops on transfer.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o) done_cnt++;
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %0d with no beat expected", out_addr_o);
        end else begin
          chk("beat_addr", 32'(out_addr_o), 32'(exp_q[0].addr));
          chk("beat_data", out_data_o, exp_q[0].data);
          chk("beat_last", 32'(out_last_o), 32'(exp_q[0].last));
          if (out_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy_o), 0);
    chk({tag, "_done"},  32'(done_o), 0);
    chk({tag, "_valid"}, 32'(out_valid_o), 0);
    chk({tag, "_last"},  32'(out_last_o), 0);
    chk({tag, "_rfaddr"}, 32'(rf_addr_o), 0);
    chk({tag, "_oaddr"}, 32'(out_addr_o), 0);
    chk({tag, "_odata"}, out_data_o, 0);
  endtask

  // mode 0 plain, 1 backpressure on addr 2, 2 start while busy, 3 reset mid-dump
  task automatic run_dump(input int mode);
    int c;
    int first_v;
    int stall;
    bit got_done;
    push_dump();
    done_cnt = 0;
    stall    = 0;
    first_v  = 0;
    got_done = 1'b0;
    start_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    c = 1;
    chk("busy_after_start", 32'(busy_o), 1);
    while (c <= 300 && !got_done) begin
      if (mode == 1 && out_valid_o && out_addr_o == 5'd2 && stall < 5) begin
        out_ready_i = 1'b0;
        stall++;
      end else begin
        out_ready_i = 1'b1;
      end
      start_i = (mode == 2 && c == 20);
      if (out_valid_o && first_v == 0) first_v = c;
      if (mode == 3 && c == 22) begin
        #2 rst_i = 1'b1;
        #1 chk_all_zero("midrst");
        exp_q.delete();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        return;
      end
      if (done_o) begin
        got_done = 1'b1;
      end else begin
        @(posedge clk_i); #1;
        c++;
      end
    end
    start_i     = 1'b0;
    out_ready_i = 1'b1;
    chk("first_valid_cycle", 32'(first_v), EXP_FIRST);
    chk("done_seen", 32'(got_done), 1);
    chk("total_cycles", 32'(c), 32'(EXP_TOTAL + ((mode == 1) ? 5 : 0)));
    chk("busy_in_fin", 32'(busy_o), 1);
    @(posedge clk_i); #1;
    chk("busy_after_done", 32'(busy_o), 0);
    chk("done_after_fin", 32'(done_o), 0);
    chk("done_pulses", 32'(done_cnt), 1);
    chk("beats_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rf_mem[i] = '0;
    rf_mem[1]   = 32'h1234_5678;
    rf_mem[2]   = 32'h8765_4321;
    rst_i       = 1'b1;
    start_i     = 1'b1;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 chk_all_zero("reset");
    start_i = 1'b0;
    rst_i   = 1'b0;
    @(posedge clk_i); #1;
    chk("idle_busy", 32'(busy_o), 0);

    run_dump(0);
    run_dump(1);
    run_dump(2);
    run_dump(3);
    repeat (2) @(posedge clk_i);
    #1 chk("post_rst_busy", 32'(busy_o), 0);
    run_dump(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
